// File: rtl/xcel_rd_arbiter.sv
// xcel_rd_arbiter: shares one 1-cycle-latency sync RAM read port between
// two byte-read requesters (0 = IFM reader, 1 = WT reader), round-robin.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_addr / reqN_ready   byte address and level request of requester N
//   reqN_dout / reqN_valid   extracted lane and its 1-cycle valid pulse
//   mem_addr / mem_en        word address and read enable to the RAM
//   mem_q                    RAM read data, one cycle after mem_en
//   stall_cnt                saturating count of cycles a request waited
//
// Option: define RD_ARB_WORD_MERGE_EN to serve both requesters with a
// single RAM read when they address the same word.
module xcel_rd_arbiter #(
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       req0_addr,
   input  logic              req0_ready,
   output logic [DWIDTH-1:0] req0_dout,
   output logic              req0_valid,
   input  logic [31:0]       req1_addr,
   input  logic              req1_ready,
   output logic [DWIDTH-1:0] req1_dout,
   output logic              req1_valid,
   output logic [AWIDTH-1:0] mem_addr,
   output logic              mem_en,
   input  logic [31:0]       mem_q,
   output logic [31:0]       stall_cnt
);

   logic              ptr;
   logic              v0_q, v1_q;
   logic [1:0]        off0_q, off1_q;
   logic [DWIDTH-1:0] hold0_q, hold1_q;
   logic [31:0]       stall_q;

   logic [AWIDTH-1:0] w0, w1;
   logic              e0, e1;
   logic              merge;
   logic              g0, g1;
   logic              stall;
   logic [DWIDTH-1:0] lane0, lane1;
   logic              unused_addr_hi;

   assign w0 = req0_addr[AWIDTH+1:2];
   assign w1 = req1_addr[AWIDTH+1:2];

   // High address bits are dropped on purpose: the RAM index wraps.
   assign unused_addr_hi = ^{req0_addr[31:AWIDTH+2],
                             req1_addr[31:AWIDTH+2]};

   // A requester's valid in this cycle means it was granted last cycle,
   // so masking on valid also masks the stale ready it still drives.
   assign e0 = req0_ready & ~v0_q & ~rst;
   assign e1 = req1_ready & ~v1_q & ~rst;

`ifdef RD_ARB_WORD_MERGE_EN
   assign merge = e0 & e1 & (w0 == w1);
`else
   assign merge = 1'b0;
`endif

   assign g0 = e0 & (~e1 | merge | ~ptr);
   assign g1 = e1 & (~e0 | merge |  ptr);

   assign stall = (e0 & ~g0) | (e1 & ~g1);

   assign mem_en = g0 | g1;

   always_comb begin
      mem_addr = '0;
      if (g0)
         mem_addr = w0;
      else if (g1)
         mem_addr = w1;
   end

   // Byte lane of the word returned this cycle, selected by the offset
   // captured at grant time.
   assign lane0 = DWIDTH'(mem_q >> {off0_q, 3'b000});
   assign lane1 = DWIDTH'(mem_q >> {off1_q, 3'b000});

   // RAM data only exists in the valid cycle; afterwards the captured
   // copy keeps dout stable.
   assign req0_dout  = v0_q ? lane0 : hold0_q;
   assign req1_dout  = v1_q ? lane1 : hold1_q;
   assign req0_valid = v0_q;
   assign req1_valid = v1_q;
   assign stall_cnt  = stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= 1'b0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         off0_q  <= 2'd0;
         off1_q  <= 2'd0;
         hold0_q <= '0;
         hold1_q <= '0;
         stall_q <= '0;
      end else begin
         v0_q <= g0;
         v1_q <= g1;
         if (g0)
            off0_q <= req0_addr[1:0];
         if (g1)
            off1_q <= req1_addr[1:0];
         if (v0_q)
            hold0_q <= lane0;
         if (v1_q)
            hold1_q <= lane1;
         // Only a real two-way conflict moves the priority.
         if (e0 & e1 & ~merge)
            ptr <= ~ptr;
         if (stall && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
      end
   end

endmodule
